// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit with run-time op select,
// a single-bit reduction mode and a saturating handed-off-result counter.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             reduce,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] count
);

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic             s1_reduce;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] result;
    logic             red_bit;
    logic             s2_adv;
    logic             s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        red_bit = 1'b0;
        result  = '0;
        case (s1_op)
            3'b000:  begin result = s1_a & s1_b;    red_bit = &s1_a;    end
            3'b001:  begin result = s1_a | s1_b;    red_bit = |s1_a;    end
            3'b010:  begin result = s1_a ^ s1_b;    red_bit = ^s1_a;    end
            3'b011:  begin result = ~(s1_a & s1_b); red_bit = ~&s1_a;   end
            3'b100:  begin result = ~(s1_a | s1_b); red_bit = ~|s1_a;   end
            3'b101:  begin result = ~(s1_a ^ s1_b); red_bit = ~^s1_a;   end
            3'b110:  begin result = ~s1_a;          red_bit = ~s1_a[0]; end
            default: begin result = s1_a;           red_bit = s1_a[0];  end
        endcase
        // Reduction mode puts the single reduced bit in y[0] and zeroes the rest.
        if (s1_reduce) begin
            result    = '0;
            result[0] = red_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_reduce <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            count     <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid)
                    y <= result;
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op     <= op;
                    s1_reduce <= reduce;
                    s1_a      <= a;
                    s1_b      <= b;
                end
            end
            if (out_valid && out_ready && (count != {CNT_W{1'b1}}))
                count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed, table-driven bench for logic_gate_pipe: 8-bit, 1-bit and
// 2-bit-counter instances sharing one clock and reset.
module tb_logic_gate_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_reduce;
    logic [2:0]  w8_op;
    logic [7:0]  w8_a, w8_b, w8_y;
    logic [15:0] w8_count;

    logic        w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_reduce;
    logic [2:0]  w1_op;
    logic        w1_a, w1_b, w1_y;
    logic [15:0] w1_count;

    logic        sc_in_valid, sc_in_ready, sc_out_valid, sc_out_ready, sc_reduce;
    logic [2:0]  sc_op;
    logic [7:0]  sc_a, sc_b, sc_y;
    logic [1:0]  sc_count;

    logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .op(w8_op), .reduce(w8_reduce), .a(w8_a), .b(w8_b),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready), .y(w8_y), .count(w8_count));

    logic_gate_pipe #(.WIDTH(1), .CNT_W(16)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .op(w1_op), .reduce(w1_reduce), .a(w1_a), .b(w1_b),
        .out_valid(w1_out_valid), .out_ready(w1_out_ready), .y(w1_y), .count(w1_count));

    logic_gate_pipe #(.WIDTH(8), .CNT_W(2)) dut_sc (
        .clk(clk), .rst(rst), .in_valid(sc_in_valid), .in_ready(sc_in_ready),
        .op(sc_op), .reduce(sc_reduce), .a(sc_a), .b(sc_b),
        .out_valid(sc_out_valid), .out_ready(sc_out_ready), .y(sc_y), .count(sc_count));

    typedef struct {
        logic [2:0] op;
        logic       red;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int dut, input logic v, input logic [2:0] op,
                                 input logic red, input logic [7:0] a, input logic [7:0] b);
        if (dut == 0) begin
            w8_in_valid = v; w8_op = op; w8_reduce = red; w8_a = a; w8_b = b;
        end else if (dut == 1) begin
            w1_in_valid = v; w1_op = op; w1_reduce = red; w1_a = a[0]; w1_b = b[0];
        end else begin
            sc_in_valid = v; sc_op = op; sc_reduce = red; sc_a = a; sc_b = b;
        end
    endtask

    // Streams the vector queue back-to-back; result j must appear exactly two edges after its beat.
    task automatic runVectors(input int dut, input string tag);
        int   n;
        logic ov;
        logic [7:0] yv;
        n = vecs.size();
        for (int j = 0; j < n + 2; j++) begin
            @(negedge clk);
            ov = (dut == 0) ? w8_out_valid : w1_out_valid;
            yv = (dut == 0) ? w8_y : {7'b0, w1_y};
            if (j >= 2) begin
                checkOutput($sformatf("%s_valid%0d", tag, j - 2), {31'b0, ov}, 32'd1);
                checkOutput($sformatf("%s_y%0d", tag, j - 2), {24'b0, yv}, {24'b0, vecs[j-2].exp});
            end else begin
                checkOutput($sformatf("%s_lead%0d", tag, j), {31'b0, ov}, 32'd0);
            end
            if (j < n)
                applyStimulus(dut, 1'b1, vecs[j].op, vecs[j].red, vecs[j].a, vecs[j].b);
            else
                applyStimulus(dut, 1'b0, 3'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic addVec(input logic [2:0] op, input logic red, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
        vec_t v;
        v.op = op; v.red = red; v.a = a; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] tt [8];
        logic [1:0] ab;
        logic [3:0] row;

        rst = 1'b1;
        applyStimulus(0, 1'b0, 3'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1, 1'b0, 3'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(2, 1'b0, 3'b0, 1'b0, 8'h00, 8'h00);
        w8_out_ready = 1'b1;
        w1_out_ready = 1'b1;
        sc_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_out_valid", {31'b0, w8_out_valid}, 32'd0);
        checkOutput("reset_y", {24'b0, w8_y}, 32'd0);
        checkOutput("reset_count", {16'b0, w8_count}, 32'd0);
        checkOutput("reset_in_ready", {31'b0, w8_in_ready}, 32'd1);

        // 1-bit truth tables, bit index {a,b}
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
        vecs.delete();
        for (int o = 0; o < 8; o++) begin
            for (int k = 0; k < 4; k++) begin
                ab  = k[1:0];
                row = tt[o];
                addVec(o[2:0], 1'b0, {7'b0, ab[1]}, {7'b0, ab[0]}, {7'b0, row[k]});
            end
        end
        runVectors(1, "tt1");

        vecs.delete();
        addVec(3'b000, 1'b0, 8'hF0, 8'h3C, 8'h30);
        addVec(3'b001, 1'b0, 8'hF0, 8'h3C, 8'hFC);
        addVec(3'b010, 1'b0, 8'hF0, 8'h3C, 8'hCC);
        addVec(3'b011, 1'b0, 8'hF0, 8'h3C, 8'hCF);
        addVec(3'b100, 1'b0, 8'hF0, 8'h3C, 8'h03);
        addVec(3'b101, 1'b0, 8'hF0, 8'h3C, 8'h33);
        addVec(3'b110, 1'b0, 8'hF0, 8'h3C, 8'h0F);
        addVec(3'b111, 1'b0, 8'hF0, 8'h3C, 8'hF0);
        runVectors(0, "bitwise");
        @(negedge clk);
        checkOutput("bitwise_count", {16'b0, w8_count}, 32'd8);

        vecs.delete();
        addVec(3'b010, 1'b1, 8'h07, 8'hAA, 8'h01);
        addVec(3'b000, 1'b1, 8'h07, 8'hAA, 8'h00);
        addVec(3'b001, 1'b1, 8'h07, 8'hAA, 8'h01);
        addVec(3'b000, 1'b1, 8'hFF, 8'h00, 8'h01);
        addVec(3'b011, 1'b1, 8'hFF, 8'h00, 8'h00);
        addVec(3'b100, 1'b1, 8'h00, 8'hFF, 8'h01);
        addVec(3'b101, 1'b1, 8'h03, 8'h00, 8'h01);
        addVec(3'b110, 1'b1, 8'h80, 8'h00, 8'h01);
        addVec(3'b111, 1'b1, 8'h80, 8'h00, 8'h00);
        runVectors(0, "reduce");

        // Backpressure: fill the pipe with A,B, hold C, then drain.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w8_out_ready = 1'b0;
        checkOutput("bp_ready_a", {31'b0, w8_in_ready}, 32'd1);
        applyStimulus(0, 1'b1, 3'b000, 1'b0, 8'hFF, 8'h11);
        @(negedge clk);
        checkOutput("bp_ready_b", {31'b0, w8_in_ready}, 32'd1);
        applyStimulus(0, 1'b1, 3'b001, 1'b0, 8'h20, 8'h02);
        @(negedge clk);
        checkOutput("bp_ready_full", {31'b0, w8_in_ready}, 32'd0);
        checkOutput("bp_valid_a", {31'b0, w8_out_valid}, 32'd1);
        checkOutput("bp_y_a", {24'b0, w8_y}, 32'h11);
        applyStimulus(0, 1'b1, 3'b010, 1'b0, 8'h3C, 8'h0F);
        @(negedge clk);
        checkOutput("bp_ready_held", {31'b0, w8_in_ready}, 32'd0);
        checkOutput("bp_y_stable", {24'b0, w8_y}, 32'h11);
        w8_out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_drain", {31'b0, w8_in_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 3'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("bp_y_b", {24'b0, w8_y}, 32'h22);
        @(negedge clk);
        checkOutput("bp_y_c", {24'b0, w8_y}, 32'h33);
        checkOutput("bp_valid_c", {31'b0, w8_out_valid}, 32'd1);
        @(negedge clk);
        checkOutput("bp_empty", {31'b0, w8_out_valid}, 32'd0);
        checkOutput("bp_count", {16'b0, w8_count}, 32'd3);

        // Reset with two beats in flight and an output transfer pending.
        w8_out_ready = 1'b0;
        applyStimulus(0, 1'b1, 3'b111, 1'b0, 8'h5A, 8'h00);
        @(negedge clk);
        applyStimulus(0, 1'b1, 3'b111, 1'b0, 8'hA5, 8'h00);
        @(negedge clk);
        applyStimulus(0, 1'b0, 3'b0, 1'b0, 8'h00, 8'h00);
        w8_out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_out_valid", {31'b0, w8_out_valid}, 32'd0);
        checkOutput("rst_y", {24'b0, w8_y}, 32'd0);
        checkOutput("rst_count", {16'b0, w8_count}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, w8_in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_no_ghost%0d", k), {31'b0, w8_out_valid}, 32'd0);
        end

        // Saturation with a 2-bit counter: transfers land after negedges 2..6.
        for (int j = 0; j < 8; j++) begin
            if (j >= 3)
                checkOutput($sformatf("sat_count%0d", j - 2), {30'b0, sc_count},
                            (j - 2 > 3) ? 32'd3 : 32'(j - 2));
            applyStimulus(2, (j < 5), 3'b111, 1'b0, 8'(j + 1), 8'h00);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
